// File: rtl/cw_tx_sequencer_pkg.sv
// cw_tx_sequencer_pkg: state encoding, grant codes and default timeout for the CW TX sequencer
package cw_tx_sequencer_pkg;
`ifdef CW_TX_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, PREKEY, KEYED, HANG, LOCKOUT} cw_state_t;
`else
  typedef enum logic [1:0] {IDLE, PREKEY, KEYED, HANG} cw_state_t;
`endif
  localparam logic [1:0] GRANT_NONE     = 2'd0;
  localparam logic [1:0] GRANT_STRAIGHT = 2'd1;
  localparam logic [1:0] GRANT_IAMBIC   = 2'd2;
  localparam logic [1:0] GRANT_HOST     = 2'd3;
  localparam int TOT_MS_DEFAULT = 10000;
endpackage

// File: rtl/cw_ms_timer.sv
// cw_ms_timer: do1k-driven saturating millisecond counter with clear and live compare
module cw_ms_timer #(
  parameter int W = 10
) (
  input  logic         IF_clk,
  input  logic         IF_rst,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         hit
);
  logic [W-1:0] cnt;
  // clear wins over a coincident tick; the count sticks at all-ones instead of wrapping
  always_ff @(posedge IF_clk or posedge IF_rst)
    if (IF_rst) cnt <= '0;
    else cnt <= clr ? '0 : (tick && !(&cnt)) ? cnt + 1'b1 : cnt;
  assign hit = cnt == limit;
endmodule

// File: rtl/cw_tx_sequencer.sv
// cw_tx_sequencer: T/R relay and carrier sequencing for straight/iambic/host CW; CW_TX_TIMEOUT_EN adds key-down timeout lockout
module cw_tx_sequencer
  import cw_tx_sequencer_pkg::*;
#(
  parameter int TOT_MS = TOT_MS_DEFAULT
) (
  input  logic       IF_clk,
  input  logic       IF_rst,
  input  logic       do1k,
  input  logic       key_straight,
  input  logic       key_iambic,
  input  logic       key_host,
  input  logic       FPGA_PTT,
  input  logic [1:0] IF_Keyer_Mode,
  input  logic [7:0] IF_CW_PTT_delay,
  input  logic [9:0] IF_CW_Hang_Time,
  output logic       tx_en,
  output logic       cw_key,
  output logic [1:0] grant,
  output logic       tot_flag
);
  cw_state_t state, state_n;
  logic [1:0] grant_n, req_grant;
  logic [9:0] limit_dh;
  logic own, el_s, el_i, hit_dh, active_n;
  assign el_s = key_straight && IF_Keyer_Mode == 2'b00;
  assign el_i = key_iambic && (IF_Keyer_Mode == 2'b01 || IF_Keyer_Mode == 2'b10);
  assign req_grant = el_s ? GRANT_STRAIGHT : el_i ? GRANT_IAMBIC : key_host ? GRANT_HOST : GRANT_NONE;
  assign own = grant == GRANT_STRAIGHT ? key_straight :
               grant == GRANT_IAMBIC   ? key_iambic   :
               grant == GRANT_HOST     ? key_host     : 1'b0;
  assign limit_dh = state == PREKEY ? {2'b00, IF_CW_PTT_delay} : IF_CW_Hang_Time;
  cw_ms_timer #(.W(10)) u_dh (
    .IF_clk(IF_clk), .IF_rst(IF_rst), .clr(state_n != state), .tick(do1k),
    .limit(limit_dh), .hit(hit_dh)
  );
`ifdef CW_TX_TIMEOUT_EN
  localparam logic [13:0] TOT_LIM = 14'(TOT_MS);
  logic hit_tot;
  cw_ms_timer #(.W(14)) u_tot (
    .IF_clk(IF_clk), .IF_rst(IF_rst), .clr(state != KEYED), .tick(do1k),
    .limit(TOT_LIM), .hit(hit_tot)
  );
  assign active_n = state_n != IDLE && state_n != LOCKOUT;
`else
  assign active_n = state_n != IDLE;
`endif
  // next state; key drop outranks the delay compare so a short tap never emits carrier
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req_grant != GRANT_NONE ? PREKEY : IDLE;
      PREKEY:  state_n = !own ? HANG : hit_dh ? KEYED : PREKEY;
`ifdef CW_TX_TIMEOUT_EN
      KEYED:   state_n = hit_tot ? LOCKOUT : own ? KEYED : HANG;
      LOCKOUT: state_n = (key_straight || key_iambic || key_host) ? LOCKOUT : IDLE;
`else
      KEYED:   state_n = own ? KEYED : HANG;
`endif
      HANG:    state_n = own ? KEYED : hit_dh ? IDLE : HANG;
      default: state_n = IDLE;
    endcase
    grant_n = state == IDLE ? req_grant : state_n == IDLE ? GRANT_NONE : grant;
  end
  // outputs are registered from the next state so they move on the same edge as the state
  always_ff @(posedge IF_clk or posedge IF_rst)
    if (IF_rst) begin
      state  <= IDLE;
      grant  <= GRANT_NONE;
      tx_en  <= 1'b0;
      cw_key <= 1'b0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      tx_en  <= active_n | FPGA_PTT;
      cw_key <= state_n == KEYED;
    end
`ifdef CW_TX_TIMEOUT_EN
  // lockout indicator follows the state register
  always_ff @(posedge IF_clk or posedge IF_rst)
    if (IF_rst) tot_flag <= 1'b0;
    else tot_flag <= state_n == LOCKOUT;
`else
  assign tot_flag = 1'b0;
`endif
endmodule

// File: tb/tb_cw_tx_sequencer.sv
// tb_cw_tx_sequencer: table vectors, directed corner sequences and random stimulus against a reference model
module tb_cw_tx_sequencer;
  localparam int TOT = 50;
`ifdef CW_TX_TIMEOUT_EN
  localparam bit TOT_EN = 1'b1;
`else
  localparam bit TOT_EN = 1'b0;
`endif
  logic IF_clk = 1'b0, IF_rst = 1'b1, do1k = 1'b0;
  logic key_straight = 1'b0, key_iambic = 1'b0, key_host = 1'b0, FPGA_PTT = 1'b0;
  logic [1:0] IF_Keyer_Mode = 2'd0;
  logic [7:0] IF_CW_PTT_delay = 8'd0;
  logic [9:0] IF_CW_Hang_Time = 10'd0;
  logic tx_en, cw_key, tot_flag;
  logic [1:0] grant;
  int errors = 0, checks = 0;

  always #5 IF_clk = ~IF_clk;

  cw_tx_sequencer #(.TOT_MS(TOT)) dut (
    .IF_clk(IF_clk), .IF_rst(IF_rst), .do1k(do1k),
    .key_straight(key_straight), .key_iambic(key_iambic), .key_host(key_host),
    .FPGA_PTT(FPGA_PTT), .IF_Keyer_Mode(IF_Keyer_Mode),
    .IF_CW_PTT_delay(IF_CW_PTT_delay), .IF_CW_Hang_Time(IF_CW_Hang_Time),
    .tx_en(tx_en), .cw_key(cw_key), .grant(grant), .tot_flag(tot_flag)
  );

  // reference model: phase plus milliseconds elapsed in that phase and in key-down
  typedef enum int {P_IDLE, P_PRE, P_KEY, P_HANG, P_LOCK} ph_t;
  ph_t ph;
  int m_grant, m_ms, m_tot;
  logic m_tx, m_cw, m_tf;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; m_grant = 0; m_ms = 0; m_tot = 0;
    m_tx = 1'b0; m_cw = 1'b0; m_tf = 1'b0;
  endtask

  task automatic model_step();
    ph_t nx = ph;
    bit own;
    own = m_grant == 1 ? key_straight : m_grant == 2 ? key_iambic : m_grant == 3 ? key_host : 1'b0;
    if (ph == P_IDLE) begin
      if (key_straight && IF_Keyer_Mode == 2'd0) m_grant = 1;
      else if (key_iambic && (IF_Keyer_Mode == 2'd1 || IF_Keyer_Mode == 2'd2)) m_grant = 2;
      else if (key_host) m_grant = 3;
      if (m_grant != 0) nx = P_PRE;
    end else if (ph == P_PRE) nx = !own ? P_HANG : (m_ms == int'(IF_CW_PTT_delay)) ? P_KEY : P_PRE;
    else if (ph == P_KEY) nx = (TOT_EN && m_tot == TOT) ? P_LOCK : own ? P_KEY : P_HANG;
    else if (ph == P_HANG) nx = own ? P_KEY : (m_ms == int'(IF_CW_Hang_Time)) ? P_IDLE : P_HANG;
    else nx = (key_straight || key_iambic || key_host) ? P_LOCK : P_IDLE;
    m_tot = ph != P_KEY ? 0 : (m_tot + int'(do1k) > 16383 ? 16383 : m_tot + int'(do1k));
    m_ms = nx != ph ? 0 : (m_ms + int'(do1k) > 1023 ? 1023 : m_ms + int'(do1k));
    if (nx == P_IDLE) m_grant = 0;
    ph = nx;
    m_tx = (ph == P_PRE || ph == P_KEY || ph == P_HANG) || FPGA_PTT;
    m_cw = ph == P_KEY;
    m_tf = ph == P_LOCK;
  endtask

  task automatic cyc(bit t);
    do1k = t;
    @(posedge IF_clk);
    model_step();
    @(negedge IF_clk);
  endtask

  task automatic step(bit t);
    cyc(t);
    chk("model", {tx_en, cw_key, grant, tot_flag}, {m_tx, m_cw, 2'(m_grant), m_tf});
  endtask

  task automatic keys_off();
    key_straight = 1'b0; key_iambic = 1'b0; key_host = 1'b0; FPGA_PTT = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    keys_off();
    while ((tx_en || tot_flag) && n < 3000) begin step(1'b1); n++; end
    chk("idle_reached", {tx_en, tot_flag, grant}, 0);
  endtask

  task automatic wait_cw();
    int n = 0;
    while (!cw_key && n < 500) begin step(1'b1); n++; end
    chk("cw_up", cw_key, 1);
  endtask

  typedef struct packed {
    logic ks, ki, kh, ptt, tick;
    logic [1:0] mode;
    logic tx, cw;
    logic [1:0] g;
  } vec_t;
  vec_t tbl [23];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ticks;
    bit tx_gap;
    tbl = '{
      {5'b00000, 2'd0, 2'b00, 2'd0}, {5'b00010, 2'd0, 2'b10, 2'd0}, {5'b00000, 2'd0, 2'b00, 2'd0},
      {5'b10100, 2'd0, 2'b10, 2'd1}, {5'b10000, 2'd0, 2'b11, 2'd1}, {5'b10100, 2'd0, 2'b11, 2'd1},
      {5'b00100, 2'd0, 2'b10, 2'd1}, {5'b00101, 2'd0, 2'b10, 2'd1}, {5'b00001, 2'd0, 2'b10, 2'd1},
      {5'b00000, 2'd0, 2'b00, 2'd0}, {5'b00100, 2'd0, 2'b10, 2'd3}, {5'b00100, 2'd0, 2'b11, 2'd3},
      {5'b00000, 2'd0, 2'b10, 2'd3}, {5'b10000, 2'd0, 2'b10, 2'd3}, {5'b00001, 2'd0, 2'b10, 2'd3},
      {5'b00001, 2'd0, 2'b10, 2'd3}, {5'b00000, 2'd0, 2'b00, 2'd0}, {5'b11000, 2'd1, 2'b10, 2'd2},
      {5'b00010, 2'd1, 2'b10, 2'd2}, {5'b00011, 2'd1, 2'b10, 2'd2}, {5'b00011, 2'd1, 2'b10, 2'd2},
      {5'b00010, 2'd1, 2'b10, 2'd0}, {5'b11000, 2'd3, 2'b00, 2'd0}
    };
    model_reset();
    repeat (2) @(negedge IF_clk);
    chk("reset_state", {tx_en, cw_key, grant, tot_flag}, 0);
    IF_rst = 1'b0;

    // table: delay 0, hang 2 ms
    IF_CW_PTT_delay = 8'd0; IF_CW_Hang_Time = 10'd2;
    for (int i = 0; i < 23; i++) begin
      {key_straight, key_iambic, key_host, FPGA_PTT} = {tbl[i].ks, tbl[i].ki, tbl[i].kh, tbl[i].ptt};
      IF_Keyer_Mode = tbl[i].mode;
      cyc(tbl[i].tick);
      chk($sformatf("vec%0d", i), {tx_en, cw_key, grant}, {tbl[i].tx, tbl[i].cw, tbl[i].g});
    end
    keys_off();

    // iambic, 5 ms lead, 10 ms hang, 4 cycles per ms
    IF_Keyer_Mode = 2'd1; IF_CW_PTT_delay = 8'd5; IF_CW_Hang_Time = 10'd10;
    key_iambic = 1'b1;
    step(1'b0);
    chk("iambic_tx_1cyc", {tx_en, cw_key, grant}, {1'b1, 1'b0, 2'd2});
    ticks = 0;
    for (int i = 0; i < 80 && !cw_key; i++) begin
      if (i % 4 == 3) ticks++;
      step(i % 4 == 3);
    end
    chk("lead_ms", ticks, 5);
    chk("lead_cw", cw_key, 1);
    for (int i = 0; i < 60; i++) step(i % 4 == 3);
    key_iambic = 1'b0;
    step(1'b0);
    chk("hang_entry", {tx_en, cw_key}, 2'b10);
    ticks = 0;
    for (int i = 0; i < 200 && tx_en; i++) begin
      if (i % 4 == 3) ticks++;
      step(i % 4 == 3);
    end
    chk("hang_ms", ticks, 10);
    chk("hang_done", {tx_en, grant}, 0);

    // re-key 4 ms into a 10 ms hang
    IF_Keyer_Mode = 2'd3; IF_CW_PTT_delay = 8'd2;
    key_host = 1'b1;
    wait_cw();
    key_host = 1'b0;
    step(1'b0);
    tx_gap = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(i % 4 == 3);
      if (!tx_en || cw_key) tx_gap = 1'b1;
    end
    key_host = 1'b1;
    step(1'b0);
    chk("rekey_keyed", {cw_key, grant}, {1'b1, 2'd3});
    chk("rekey_tx_cont", tx_gap, 0);
    wait_idle();

    // key held 80 ms against a 50 ms timeout, 2 cycles per ms
    IF_CW_PTT_delay = 8'd0;
    key_host = 1'b1;
    wait_cw();
    ticks = 0;
    for (int i = 0; i < 160 && cw_key; i++) begin
      if (i % 2 == 1) ticks++;
      step(i % 2 == 1);
    end
    if (TOT_EN) begin
      chk("tot_ms", ticks, TOT);
      chk("tot_lock", {tot_flag, cw_key, tx_en}, 3'b100);
      repeat (5) step(1'b1);
      chk("tot_hold", tot_flag, 1);
      key_host = 1'b0;
      step(1'b0);
      chk("tot_release", {tot_flag, tx_en, grant}, 0);
    end else begin
      chk("no_tot_ms", ticks, 80);
      chk("no_tot_keyed", {tot_flag, cw_key, tx_en}, 3'b011);
    end
    wait_idle();

    // asynchronous reset in KEYED
    key_host = 1'b1;
    wait_cw();
    #2 IF_rst = 1'b1;
    #1 chk("async_reset", {tx_en, cw_key, grant, tot_flag}, 0);
    @(negedge IF_clk);
    IF_rst = 1'b0;
    model_reset();
    step(1'b0);
    chk("restart_prekey", {tx_en, cw_key, grant}, {1'b1, 1'b0, 2'd3});
    wait_idle();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) key_straight = ~key_straight;
      if ($urandom_range(0, 11) == 0) key_iambic = ~key_iambic;
      if ($urandom_range(0, 15) == 0) key_host = ~key_host;
      if ($urandom_range(0, 39) == 0) FPGA_PTT = ~FPGA_PTT;
      if ($urandom_range(0, 79) == 0) IF_Keyer_Mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) IF_CW_PTT_delay = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) IF_CW_Hang_Time = 10'($urandom_range(0, 8));
      if ($urandom_range(0, 999) == 0) begin
        IF_rst = 1'b1;
        @(negedge IF_clk);
        IF_rst = 1'b0;
        model_reset();
      end
      step($urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cw_tx_sequencer.md
CW_TX_SEQUENCER -- requirements
Module: cw_tx_sequencer

Interface
REQ-001 The block SHALL have parameter TOT_MS, default 10000, setting the key-down timeout in ms (range 1-16383).
REQ-002 The block SHALL have port IF_clk, input, 1 bit: the 48 MHz clock; one clock domain only.
REQ-003 The block SHALL have port IF_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port do1k, input, 1 bit: one-IF_clk pulse every 1 ms.
REQ-005 The block SHALL have port key_straight, input, 1 bit: debounced straight key, active-high.
REQ-006 The block SHALL have port key_iambic, input, 1 bit: iambic keyer carrier request, active-high.
REQ-007 The block SHALL have port key_host, input, 1 bit: host-generated CW key, active-high.
REQ-008 The block SHALL have port FPGA_PTT, input, 1 bit: host PTT, active-high.
REQ-009 The block SHALL have port IF_Keyer_Mode, input, 2 bits: 00 straight, 01/10 iambic, 11 host only.
REQ-010 The block SHALL have port IF_CW_PTT_delay, input, 8 bits: relay lead time, 0-255 ms.
REQ-011 The block SHALL have port IF_CW_Hang_Time, input, 10 bits: hang time, 0-1023 ms.
REQ-012 The block SHALL have port tx_en, output, 1 bit: T/R relay enable, active-high.
REQ-013 The block SHALL have port cw_key, output, 1 bit: carrier on, active-high.
REQ-014 The block SHALL have port grant, output, 2 bits: owner; 0 none, 1 straight, 2 iambic, 3 host.
REQ-015 The block SHALL have port tot_flag, output, 1 bit: timeout lockout active.

Function
REQ-016 The block SHALL implement a state machine with states IDLE, PREKEY, KEYED, HANG and LOCKOUT; all outputs SHALL be registered and update on the edge that changes state.
REQ-017 Eligibility SHALL be: key_straight only when mode=00; key_iambic only when mode is 01 or 10; key_host in all modes.
REQ-018 In IDLE, any eligible request SHALL latch grant and enter PREKEY on the next edge; on simultaneous requests, priority SHALL be straight > iambic > host.
REQ-019 Grant SHALL remain locked until the machine returns to IDLE; requests from non-owner sources SHALL be ignored.
REQ-020 Entering PREKEY SHALL set tx_en=1 and cw_key=0 and clear the ms counter; each do1k SHALL increment the counter.
REQ-021 PREKEY SHALL go to KEYED when counter==IF_CW_PTT_delay; with delay 0, KEYED SHALL follow one cycle after PREKEY.
REQ-022 If the owner key drops during PREKEY, the machine SHALL go to HANG with no carrier emitted.
REQ-023 KEYED SHALL hold cw_key=1 and tx_en=1; when the owner key drops, the next edge SHALL go to HANG with cw_key=0 and clear the counter.
REQ-024 In HANG, tx_en=1 and cw_key=0; owner key high SHALL return to KEYED next edge (no re-delay); counter==IF_CW_Hang_Time SHALL go to IDLE, with grant=0 and tx_en=FPGA_PTT.
REQ-025 In every state, tx_en SHALL be the state value OR FPGA_PTT, registered; FPGA_PTT SHALL never assert cw_key.
REQ-026 Counters SHALL saturate and never wrap; configuration changes mid-operation SHALL take effect at the next compare.
REQ-027 Tick resolution SHALL be -1/+0 ms, because the first partial ms counts.

Reset
REQ-028 While IF_rst=1, the state SHALL be IDLE, tx_en=0, cw_key=0, grant=0, tot_flag=0 and all counters 0, immediately and asynchronously.
REQ-029 Reset asserted mid-element SHALL drop cw_key and tx_en without sequencing.

Configuration
REQ-030 When CW_TX_TIMEOUT_EN is defined, a 14-bit counter SHALL count do1k while in KEYED, clearing on KEYED exit.
REQ-031 When the timeout counter reaches TOT_MS, the block SHALL enter LOCKOUT with cw_key=0, tx_en=FPGA_PTT and tot_flag=1.
REQ-032 LOCKOUT SHALL go to IDLE only once all three key inputs are low.
REQ-033 When CW_TX_TIMEOUT_EN is not defined, no LOCKOUT state or timeout counter SHALL exist and tot_flag SHALL be tied 0.

Structure
REQ-034 A shared package SHALL hold the state encoding constants, the grant codes (GRANT_NONE/STRAIGHT/IAMBIC/HOST) and the default TOT_MS.
REQ-035 One sub-module, cw_ms_timer, SHALL provide a do1k-driven saturating counter with clear and compare, instanced for delay/hang and, if enabled, for timeout.

Verification
REQ-036 Bench scenario: mode=01, delay=5, hang=10, key_iambic high 20 ms -> tx_en rises 1 cycle later, cw_key rises about 5 ms later, tx_en falls 10 ms after cw_key falls.
REQ-037 Bench scenario: delay=0, key_host pulse -> cw_key high 2 cycles after the key sample; grant=3.
REQ-038 Bench scenario: mode=00, key_straight and key_host rise in the same cycle -> grant=1, and key_host toggling is ignored until IDLE.
REQ-039 Bench scenario: re-key after 4 ms of a 10 ms hang -> KEYED next cycle, no PREKEY, tx_en continuous.
REQ-040 Bench scenario: TOT_MS=50 with macro defined, key held 80 ms -> cw_key drops at 50 ms, tot_flag=1, IDLE only after release.
REQ-041 Bench scenario: IF_rst pulse during KEYED -> cw_key=0 and tx_en=0 asynchronously, and the block restarts from IDLE.
